// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor (4-bit groups, flat lookahead across groups).
// Latency 2 cycles from accept to out_valid; one result per cycle when out_ready is held high.
// Backpressure: valid/ready per stage; a full stall holds 2 beats, and in_ready depends only on stage state and out_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a, b, cin, sub sampled on accept
//   out_valid/out_ready result handshake; sum, cout, ovf held stable while stalled
//   sub=1 computes a + ~b + 1 (cin ignored); cout=1 then means no borrow
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;

    // Group size is hard-wired into the lookahead equations below.
    if (GROUP != 4) begin : g_bad_group
        $error("pipelined_cla_adder: GROUP must be 4");
    end
    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    // ---------------- handshake ----------------
    logic w_s1_load;
    logic w_s2_load;
    logic r_s1_vld;
    logic r_s2_vld;

    assign w_s2_load = !r_s2_vld || out_ready;
    assign w_s1_load = !r_s1_vld || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_vld;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic             r_s1_sa;
    logic             r_s1_sb;
    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff = b ^ {WIDTH{sub}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_vld <= in_valid;
        end
    end

    // Operand registers are qualified by r_s1_vld, so they need no reset.
    always_ff @(posedge clk) begin
        if (in_valid && w_s1_load) begin
            r_s1_a   <= a;
            r_s1_b   <= w_b_eff;
            r_s1_cin <= sub ? 1'b1 : cin;
            r_s1_sa  <= a[WIDTH-1];
            r_s1_sb  <= w_b_eff[WIDTH-1];
        end
    end

    // ---------------- carry lookahead ----------------
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;
    logic [NG:0]      w_cg;    // w_cg[k] = carry into group k, w_cg[NG] = carry out
    logic [WIDTH-1:0] w_c;     // carry into each bit
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             v_acc;
    logic             v_prod;

    always_comb begin
        w_p    = r_s1_a ^ r_s1_b;
        w_g    = r_s1_a & r_s1_b;
        w_gp   = '0;
        w_gg   = '0;
        w_cg   = '0;
        w_c    = '0;
        w_sum  = '0;
        v_acc  = 1'b0;
        v_prod = 1'b1;

        for (int k = 0; k < NG; k++) begin
            w_gp[k] = &w_p[4*k +: 4];
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
        end

        // Each group carry is a flat sum of products of group G/P terms and c0;
        // the loop unrolls into independent expressions, never c[k-1] -> c[k].
        w_cg[0] = r_s1_cin;
        for (int k = 1; k <= NG; k++) begin
            v_acc  = 1'b0;
            v_prod = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                v_acc  = v_acc | (w_gg[j] & v_prod);
                v_prod = v_prod & w_gp[j];
            end
            w_cg[k] = v_acc | (v_prod & r_s1_cin);
        end

        // Bit carries inside a group, looked ahead from that group's carry-in.
        for (int k = 0; k < NG; k++) begin
            for (int m = 0; m < 4; m++) begin
                v_acc  = 1'b0;
                v_prod = 1'b1;
                for (int j = m - 1; j >= 0; j--) begin
                    v_acc  = v_acc | (w_g[4*k+j] & v_prod);
                    v_prod = v_prod & w_p[4*k+j];
                end
                w_c[4*k+m] = v_acc | (v_prod & w_cg[k]);
            end
        end

        w_sum = w_p ^ w_c;
        // MSB sum bit formed from the registered sign bits (same value as w_p[MSB]).
        w_sum[WIDTH-1] = r_s1_sa ^ r_s1_sb ^ w_c[WIDTH-1];
    end

    assign w_ovf = w_c[WIDTH-1] ^ w_cg[NG];

    // ---------------- stage 2 ----------------
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_sum  <= w_sum;
                r_cout <= w_cg[NG];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder: WIDTH=4/16/64 instances share one handshake.
// Expected {ovf,cout,sum} pushed per instance on accept, popped on each output transfer.
// Directed vectors, backpressure, mid-operation reset, then random valid/ready traffic.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic [3:0]  a4,  b4;
    logic [15:0] a16, b16;
    logic [63:0] a64, b64;

    logic        rdy4, rdy16, rdy64;
    logic        ov4, ov16, ov64;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [63:0] sum64;
    logic        co4, co16, co64;
    logic        of4, of16, of64;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .a(a4), .b(b4), .cin(cin), .sub(sub),
        .out_valid(ov4), .out_ready(out_ready), .sum(sum4), .cout(co4), .ovf(of4));

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .a(a16), .b(b16), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(co16), .ovf(of16));

    pipelined_cla_adder #(.WIDTH(64), .GROUP(4)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .a(a64), .b(b64), .cin(cin), .sub(sub),
        .out_valid(ov64), .out_ready(out_ready), .sum(sum64), .cout(co64), .ovf(of64));

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard queues: index 0 = WIDTH 4, 1 = WIDTH 16, 2 = WIDTH 64; entry {ovf, cout, sum}.
    logic [65:0] sb [3][$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] mk(input logic o, input logic c, input logic [63:0] s);
        return {o, c, s};
    endfunction

    // Reference: plain wide addition, then slice out width-w results.
    function automatic logic [65:0] model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                          input logic ci, input logic si);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] be;
        logic [64:0] full;
        logic [63:0] s;
        logic        c;
        logic        o;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = ai & mask;
        be   = (si ? ~bi : bi) & mask;
        full = {1'b0, am} + {1'b0, be} + {64'd0, (si ? 1'b1 : ci)};
        s    = full[63:0] & mask;
        c    = full[w];
        o    = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
        return {o, c, s};
    endfunction

    task automatic pop_cmp(input int idx, input string nm, input logic [63:0] s,
                           input logic c, input logic o);
        logic [65:0] e;
        check({nm, "_sb_nonempty"}, 64'(sb[idx].size() != 0), 64'd1);
        if (sb[idx].size() != 0) begin
            e = sb[idx].pop_front();
            check({nm, "_sum"}, s, e[63:0]);
            check({nm, "_cout_ovf"}, {62'd0, c, o}, {62'd0, e[64], e[65]});
        end
    endtask

    // Output monitor: at the negedge, a valid&ready pair means a transfer on the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov4  && out_ready) pop_cmp(0, "w4",  {60'd0, sum4},  co4,  of4);
            if (ov16 && out_ready) pop_cmp(1, "w16", {48'd0, sum16}, co16, of16);
            if (ov64 && out_ready) pop_cmp(2, "w64", sum64,          co64, of64);
        end
    end

    // Called just after a posedge; holds the beat until accepted, then drops in_valid.
    task automatic send(input logic [63:0] ai64, input logic [63:0] bi64,
                        input logic [15:0] ai16, input logic [15:0] bi16,
                        input logic [3:0]  ai4,  input logic [3:0]  bi4,
                        input logic ci, input logic si,
                        input logic use_e, input logic [65:0] e16);
        logic acc;
        acc = 1'b0;
        a4 = ai4;   b4 = bi4;
        a16 = ai16; b16 = bi16;
        a64 = ai64; b64 = bi64;
        cin = ci;   sub = si;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (rdy16) begin
                acc = 1'b1;
                sb[0].push_back(model(4,  {60'd0, ai4},  {60'd0, bi4},  ci, si));
                sb[1].push_back(use_e ? e16 : model(16, {48'd0, ai16}, {48'd0, bi16}, ci, si));
                sb[2].push_back(model(64, ai64, bi64, ci, si));
            end
        end
        check("accept_within_bound", {63'd0, acc}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                          input logic si, input logic use_e, input logic [65:0] e16);
        send({ai, ai, ai, ai}, {bi, bi, bi, bi}, ai, bi, ai[3:0], bi[3:0], ci, si, use_e, e16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    logic done;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        a4 = '0; b4 = '0; a16 = '0; b16 = '0; a64 = '0; b64 = '0;
        done = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", {61'd0, ov4, ov16, ov64}, 64'd0);
        check("rst_sum16", {48'd0, sum16}, 64'd0);
        check("rst_flags16", {62'd0, co16, of16}, 64'd0);
        check("rst_in_ready", {61'd0, rdy4, rdy16, rdy64}, 64'd7);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Latency: first beat accepted on the first edge after release, valid 2 edges later
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 64'h0));
        @(negedge clk); check("lat_cycle1_not_valid", {63'd0, ov16}, 64'd0);
        @(negedge clk); check("lat_cycle2_valid", {63'd0, ov16}, 64'd1);
        @(negedge clk); check("s2_clears_when_s1_empty", {63'd0, ov16}, 64'd0);
        @(posedge clk); #1;

        // Directed vectors back to back
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 64'h8000));
        send16(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, mk(1'b1, 1'b1, 64'h7FFF));
        send16(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 64'hFFFE));
        send16(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b0, 66'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Backpressure: X1, X2 accepted, X3 waits while out_ready is low for 4 edges
        out_ready = 1'b0;
        fork
            begin
                send16(16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 66'd0);
                send16(16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 66'd0);
                send16(16'd3, 16'd3, 1'b0, 1'b0, 1'b0, 66'd0);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_full_in_ready", {63'd0, rdy16}, 64'd0);
                check("bp_full_out_valid", {63'd0, ov16}, 64'd1);
                check("bp_hold_sum_a", {48'd0, sum16}, 64'h2);
                @(negedge clk);
                check("bp_hold_in_ready", {63'd0, rdy16}, 64'd0);
                check("bp_hold_sum_b", {48'd0, sum16}, 64'h2);
                @(posedge clk); #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_rel_in_ready", {63'd0, rdy16}, 64'd1);
                check("bp_rel_r1", {47'd0, ov16, sum16}, {47'd0, 1'b1, 16'h0002});
                @(negedge clk);
                check("bp_rel_r2", {47'd0, ov16, sum16}, {47'd0, 1'b1, 16'h0004});
                @(negedge clk);
                check("bp_rel_r3", {47'd0, ov16, sum16}, {47'd0, 1'b1, 16'h0006});
            end
        join
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        // Reset with two beats in flight
        out_ready = 1'b0;
        send16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 66'd0);
        send16(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0, 66'd0);
        @(negedge clk);
        check("mid_rst_pre_full", {62'd0, ov16, rdy16}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid_drop", {61'd0, ov4, ov16, ov64}, 64'd0);
        check("mid_rst_sum_clear", {48'd0, sum16}, 64'd0);
        check("mid_rst_in_ready", {63'd0, rdy16}, 64'd1);
        for (int i = 0; i < 3; i++) sb[i].delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", {61'd0, ov4, ov16, ov64}, 64'd0);
        end
        @(posedge clk); #1;

        // Random traffic with random out_ready
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send({$urandom, $urandom}, {$urandom, $urandom},
                         16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                         1'($urandom), 1'($urandom), 1'b0, 66'd0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int t = 0; t < 20 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; t++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_w4",  64'(sb[0].size()), 64'd0);
        check("drain_w16", 64'(sb[1].size()), 64'd0);
        check("drain_w64", 64'(sb[2].size()), 64'd0);
        check("idle_out_valid", {61'd0, ov4, ov16, ov64}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
